// File: rtl/serial_link_pkg.sv
// Constants and state encoding shared by both ends of the serial ROM-word link.
package serial_link_pkg;

  localparam int SINE_WORD_W       = 32;
  localparam int DEF_TIMEOUT_TICKS = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } rx_state_e;

endpackage

// File: rtl/edge_detect_rise.sv
// Registers a level signal and reports its rising edge in the same cycle it appears.
module edge_detect_rise (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic sig_q;
  logic sig_d;

  always_comb begin
    sig_d = sig;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Deserializes the MSB-first SO stream into WIDTH-bit words, framed by soc rising edges.
module serial_word_receiver
  import serial_link_pkg::*;
#(
  parameter int WIDTH         = SINE_WORD_W,
  parameter int TIMEOUT_TICKS = DEF_TIMEOUT_TICKS,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             SI,
  input  logic             SI_en,
  input  logic             soc,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_err,
  output logic             busy,
  output logic [CNT_W-1:0] word_count
);

  localparam int BIT_W = $clog2(WIDTH + 1);
  localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(WIDTH - 1);
  localparam logic [TO_W-1:0]  LAST_STALL = TO_W'(TIMEOUT_TICKS - 1);

  rx_state_e        state_q, state_d;
  logic [WIDTH-2:0] shift_q, shift_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [CNT_W-1:0] word_count_q, word_count_d;
  logic             soc_rise;
  logic             bit_ok;
  logic             stall_tick;
  logic             final_bit;

  edge_detect_rise u_soc_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (soc),
    .rise (soc_rise)
  );

  assign bit_ok     = (state_q == ST_SHIFT) & tick & SI_en;
  assign stall_tick = (state_q == ST_SHIFT) & tick & ~SI_en;
  assign final_bit  = bit_ok & (bit_cnt_q == LAST_BIT);

  // The shifter holds only WIDTH-1 bits: the final bit joins them directly on completion.
  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    to_cnt_d     = to_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    word_count_d = word_count_q;

    case (state_q)
      ST_IDLE: begin
        if (soc_rise) begin
          state_d   = ST_SHIFT;
          shift_d   = '0;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (final_bit) begin
          data_out_d   = {shift_q, SI};
          data_valid_d = 1'b1;
          word_count_d = word_count_q + CNT_W'(1);
          shift_d      = '0;
          bit_cnt_d    = '0;
          to_cnt_d     = '0;
          state_d      = soc_rise ? ST_SHIFT : ST_IDLE;
        end else if (soc_rise) begin
          frame_err_d = 1'b1;
          shift_d     = '0;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
        end else if (bit_ok) begin
          shift_d   = {shift_q[WIDTH-3:0], SI};
          bit_cnt_d = bit_cnt_q + BIT_W'(1);
          to_cnt_d  = '0;
        end else if (stall_tick) begin
          if (to_cnt_q == LAST_STALL) begin
            frame_err_d = 1'b1;
            shift_d     = '0;
            bit_cnt_d   = '0;
            to_cnt_d    = '0;
            state_d     = ST_IDLE;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      to_cnt_q     <= to_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      word_count_q <= word_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign busy       = (state_q == ST_SHIFT);
  assign word_count = word_count_q;

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: frame-level vector table, directed corner sequences
// and randomized traffic, all checked every cycle against a bit-queue reference model.
module tb_serial_word_receiver;

  localparam int W  = 32;
  localparam int TO = 64;

  logic        clk;
  logic        rst;
  logic        tick;
  logic        SI;
  logic        SI_en;
  logic        soc;
  logic [31:0] data_out,   data_out4;
  logic        data_valid, data_valid4;
  logic        frame_err,  frame_err4;
  logic        busy,       busy4;
  logic [15:0] word_count;
  logic [3:0]  word_count4;

  serial_word_receiver dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .SI         (SI),
    .SI_en      (SI_en),
    .soc        (soc),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .word_count (word_count)
  );

  // Narrow-counter instance sharing the same stimulus, used to observe counter wrap.
  serial_word_receiver #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .SI         (SI),
    .SI_en      (SI_en),
    .soc        (soc),
    .data_out   (data_out4),
    .data_valid (data_valid4),
    .frame_err  (frame_err4),
    .busy       (busy4),
    .word_count (word_count4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: a frame is a list of received bits; a word is folded arithmetically.
  bit          m_in_frame = 1'b0;
  bit          m_bits[$];
  int          m_stall    = 0;
  bit          m_prev_soc = 1'b0;
  logic [31:0] m_data     = '0;
  int          m_count    = 0;
  bit          exp_valid  = 1'b0;
  bit          exp_err    = 1'b0;

  int          seen_valid = 0;
  int          seen_err   = 0;
  logic [31:0] seen_words[$];

  task automatic modelStep();
    bit          rise;
    longint      word;
    rise       = soc && !m_prev_soc;
    m_prev_soc = soc;
    exp_valid  = 1'b0;
    exp_err    = 1'b0;
    if (rst) begin
      m_in_frame = 1'b0;
      m_bits.delete();
      m_stall    = 0;
      m_prev_soc = 1'b0;
      m_data     = '0;
      m_count    = 0;
    end else if (!m_in_frame) begin
      if (rise) begin
        m_in_frame = 1'b1;
        m_bits.delete();
        m_stall = 0;
      end
    end else if (tick && SI_en && m_bits.size() == W - 1) begin
      m_bits.push_back(SI);
      word = 0;
      foreach (m_bits[i]) word = word * 2 + longint'(m_bits[i]);
      m_data     = 32'(word);
      exp_valid  = 1'b1;
      m_count    = m_count + 1;
      m_bits.delete();
      m_stall    = 0;
      m_in_frame = rise;
    end else if (rise) begin
      exp_err = 1'b1;
      m_bits.delete();
      m_stall = 0;
    end else if (tick && SI_en) begin
      m_bits.push_back(SI);
      m_stall = 0;
    end else if (tick) begin
      m_stall = m_stall + 1;
      if (m_stall == TO) begin
        exp_err    = 1'b1;
        m_in_frame = 1'b0;
        m_bits.delete();
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    logic [50:0] act_main, exp_main;
    logic [38:0] act_narrow, exp_narrow;
    act_main   = {data_out, data_valid, frame_err, busy, word_count};
    exp_main   = {m_data, exp_valid, exp_err, m_in_frame, 16'(m_count)};
    act_narrow = {data_out4, data_valid4, frame_err4, busy4, word_count4};
    exp_narrow = {m_data, exp_valid, exp_err, m_in_frame, 4'(m_count)};
    n_cmp++;
    if (act_main !== exp_main || act_narrow !== exp_narrow) begin
      n_fail++;
      $display("[TB] FAIL cycle@%0t: got {data,v,e,busy,cnt}=%h / narrow %h, want %h / %h",
               $time, act_main, act_narrow, exp_main, exp_narrow);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic s,
                               input logic e, input logic c);
    rst   = r;
    tick  = t;
    SI    = s;
    SI_en = e;
    soc   = c;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput();
    if (data_valid) begin
      seen_valid++;
      seen_words.push_back(data_out);
    end
    if (frame_err) seen_err++;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic sendFrame(input logic [31:0] word, input int nbits, input int stall_at,
                           input int stall_len, input bit start_soc, input bit soc_on_last);
    if (start_soc) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      if (i == stall_at) begin
        for (int k = 0; k < stall_len; k++) begin
          applyStimulus(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
          applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
        end
      end
      applyStimulus(1'b0, 1'b1, word[31-i], 1'b1, soc_on_last && (i == nbits - 1));
      applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  task automatic clearSeen();
    seen_valid = 0;
    seen_err   = 0;
    seen_words.delete();
  endtask

  typedef struct {
    logic [31:0] word;
    int          stall_at;
    int          stall_len;
    int          exp_valid_n;
    int          exp_err_n;
    logic [31:0] exp_data;
    int          exp_count;
  } vec_t;

  vec_t vecs[5];
  int   en_pct;

  initial begin
    vecs[0] = '{32'hA5A5_0F0F, -1,  0, 1, 0, 32'hA5A5_0F0F, 1};
    vecs[1] = '{32'hDEAD_BEEF, 16, 63, 1, 0, 32'hDEAD_BEEF, 2};
    vecs[2] = '{32'h1357_9BDF,  5, 64, 0, 1, 32'hDEAD_BEEF, 2};
    vecs[3] = '{32'h0000_0000, -1,  0, 1, 0, 32'h0000_0000, 3};
    vecs[4] = '{32'hFFFF_FFFF, 31, 10, 1, 0, 32'hFFFF_FFFF, 4};

    // Power-on reset: every output must read zero.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkValue("reset data_out", data_out, 32'h0);
    checkValue("reset flags", {29'd0, data_valid, frame_err, busy}, 32'h0);
    checkValue("reset word_count", {16'd0, word_count}, 32'h0);
    idleCycles(2);

    // Frame-level vectors: nominal, tolerated stall, timeout, boundary patterns.
    foreach (vecs[v]) begin
      clearSeen();
      sendFrame(vecs[v].word, W, vecs[v].stall_at, vecs[v].stall_len, 1'b1, 1'b0);
      idleCycles(4);
      checkValue($sformatf("vec%0d valid pulses", v), 32'(seen_valid), 32'(vecs[v].exp_valid_n));
      checkValue($sformatf("vec%0d err pulses", v), 32'(seen_err), 32'(vecs[v].exp_err_n));
      checkValue($sformatf("vec%0d data_out", v), data_out, vecs[v].exp_data);
      checkValue($sformatf("vec%0d word_count", v), {16'd0, word_count}, 32'(vecs[v].exp_count));
      checkValue($sformatf("vec%0d busy", v), {31'd0, busy}, 32'h0);
    end

    // Back-to-back frames: next soc rises on the cycle of each final bit.
    clearSeen();
    sendFrame(32'h0000_0001, W, -1, 0, 1'b1, 1'b1);
    sendFrame(32'h7FFF_FFFF, W, -1, 0, 1'b0, 1'b1);
    sendFrame(32'h8000_0000, W, -1, 0, 1'b0, 1'b0);
    idleCycles(3);
    checkValue("b2b valid pulses", 32'(seen_valid), 32'd3);
    checkValue("b2b err pulses", 32'(seen_err), 32'd0);
    if (seen_words.size() == 3) begin
      checkValue("b2b word0", seen_words[0], 32'h0000_0001);
      checkValue("b2b word1", seen_words[1], 32'h7FFF_FFFF);
      checkValue("b2b word2", seen_words[2], 32'h8000_0000);
    end
    checkValue("b2b word_count", {16'd0, word_count}, 32'd7);

    // Abort: a new soc after 10 bits resynchronizes onto the following frame.
    clearSeen();
    sendFrame(32'hFFFF_FFFF, 10, -1, 0, 1'b1, 1'b0);
    sendFrame(32'h1234_5678, W, -1, 0, 1'b1, 1'b0);
    idleCycles(3);
    checkValue("abort err pulses", 32'(seen_err), 32'd1);
    checkValue("abort valid pulses", 32'(seen_valid), 32'd1);
    checkValue("abort data_out", data_out, 32'h1234_5678);
    checkValue("abort word_count", {16'd0, word_count}, 32'd8);

    // Reset after 20 bits: partial word dropped silently.
    clearSeen();
    sendFrame($urandom, 20, -1, 0, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    checkValue("midrst data_out", data_out, 32'h0);
    checkValue("midrst flags", {29'd0, data_valid, frame_err, busy}, 32'h0);
    checkValue("midrst word_count", {16'd0, word_count}, 32'h0);
    idleCycles(2);
    checkValue("midrst err pulses", 32'(seen_err), 32'd0);

    // Counter wrap: 17 good words on the 4-bit counter leaves 1.
    for (int f = 0; f < 17; f++) sendFrame($urandom, W, -1, 0, 1'b1, 1'b0);
    idleCycles(2);
    checkValue("wrap word_count16", {16'd0, word_count}, 32'd17);
    checkValue("wrap word_count4", {28'd0, word_count4}, 32'd1);

    // Randomized traffic with varying bit-enable density and occasional reset.
    for (int c = 0; c < 6000; c++) begin
      case ((c / 600) % 4)
        0: en_pct = 95;
        1: en_pct = 60;
        2: en_pct = 2;
        default: en_pct = 85;
      endcase
      applyStimulus($urandom_range(1499, 0) == 0,
                    $urandom_range(1, 0) == 1,
                    $urandom_range(1, 0) == 1,
                    $urandom_range(99, 0) < en_pct,
                    $urandom_range(119, 0) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
